// File: rtl/gray_decoder_checker_pkg.sv
// Shared types and helpers for the gray-coded count interface (encoder and decoder sides).
package gray_decoder_checker_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_SUSPECT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_BAD  = 2'd3
    } step_e;

    localparam int unsigned GRAY_MAX_W = 32;

    // Works for any width up to GRAY_MAX_W: zero-extended upper bits leave the prefix XOR unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int unsigned k = 1; k < GRAY_MAX_W; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decoder_checker_sync.sv
// Multi-flop vector synchronizer for gray-coded buses crossing into clk.
module gray_sync #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES*WIDTH-1:0] chain_q;

    if (STAGES == 1) begin : g_single
        always_ff @(posedge clk or posedge reset) begin
            if (reset) chain_q <= '0;
            else       chain_q <= d_i;
        end
    end else begin : g_multi
        always_ff @(posedge clk or posedge reset) begin
            if (reset) chain_q <= '0;
            else       chain_q <= {chain_q[(STAGES-1)*WIDTH-1:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/gray_decoder_checker.sv
// Gray count receiver: synchronize, decode to binary, and police single-step transitions.
module gray_decoder_checker
    import gray_decoder_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOSS_COUNT  = 3,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             sample_en,
    input  logic             clear_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             dir_up,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned BC_W = $clog2(LOSS_COUNT + 1);

    logic [WIDTH-1:0] g_s, b, delta;
    logic [WIDTH-1:0] bin_q, prev_q;
    logic             valid_q, step_err_q, step_err_d, dir_q, dir_d, locked_q;
    logic [ERR_W-1:0] err_q, err_d, err_base;
    logic [BC_W-1:0]  bad_q, bad_d, bad_next;
    state_e           state_q, state_d;
    step_e            step;

    gray_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (gray_in),
        .q_o   (g_s)
    );

    assign b     = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));
    assign delta = b - prev_q;

    always_comb begin
        if (delta == '0)                step = STEP_HOLD;
        else if (delta == WIDTH'(1))    step = STEP_UP;
        else if (delta == '1)           step = STEP_DOWN;
        else                            step = STEP_BAD;
    end

    always_comb begin
        state_d    = state_q;
        bad_d      = bad_q;
        dir_d      = dir_q;
        step_err_d = 1'b0;
        bad_next   = (state_q == ST_LOCKED) ? BC_W'(1) : bad_q + BC_W'(1);
        if (sample_en) begin
            case (state_q)
                ST_UNLOCKED: begin
                    state_d = ST_LOCKED;
                    bad_d   = '0;
                end
                default: begin
                    if (step == STEP_BAD) begin
                        step_err_d = 1'b1;
                        if (32'(bad_next) >= LOSS_COUNT) begin
                            state_d = ST_UNLOCKED;
                            bad_d   = '0;
                        end else begin
                            state_d = ST_SUSPECT;
                            bad_d   = bad_next;
                        end
                    end else begin
                        if (step == STEP_UP)   dir_d = 1'b1;
                        if (step == STEP_DOWN) dir_d = 1'b0;
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                    end
                end
            endcase
        end
        // Clear applies first so a same-cycle illegal step still counts once.
        err_base = clear_err ? '0 : err_q;
        err_d    = (step_err_d && (err_base != '1)) ? err_base + ERR_W'(1) : err_base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_UNLOCKED;
            bad_q      <= '0;
            dir_q      <= 1'b0;
            err_q      <= '0;
            bin_q      <= '0;
            prev_q     <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bad_q      <= bad_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            valid_q    <= sample_en;
            step_err_q <= step_err_d;
            locked_q   <= (state_d != ST_UNLOCKED);
            if (sample_en) begin
                bin_q  <= b;
                prev_q <= b;
            end
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign step_err  = step_err_q;
    assign dir_up    = dir_q;
    assign locked    = locked_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Directed bench for gray_decoder_checker (WIDTH=5, SYNC_STAGES=2, LOSS_COUNT=3, ERR_W=8).
module tb_gray_decoder_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] gray_in = '0;
    logic       sample_en = 1'b0;
    logic       clear_err = 1'b0;
    logic [4:0] bin_out;
    logic       bin_valid, step_err, dir_up, locked;
    logic [7:0] err_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    gray_decoder_checker #(
        .WIDTH       (5),
        .SYNC_STAGES (2),
        .LOSS_COUNT  (3),
        .ERR_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .sample_en (sample_en),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .dir_up    (dir_up),
        .locked    (locked),
        .err_count (err_count)
    );

    function automatic logic [4:0] to_gray(input logic [4:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let the value settle through the sync chain, then sample it for one cycle.
    task automatic present(input logic [4:0] g, input logic clr);
        gray_in   = g;
        sample_en = 1'b0;
        clear_err = 1'b0;
        tick();
        tick();
        sample_en = 1'b1;
        clear_err = clr;
        tick();
        sample_en = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; gray_in = '0; sample_en = 1'b0; clear_err = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (bin_out   !== 5'd0) begin n_bad++; $display("FAIL reset_bin_out: got %0d want 0", bin_out); end
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bin_valid: got %b want 0", bin_valid); end
        n_cmp++; if (step_err  !== 1'b0) begin n_bad++; $display("FAIL reset_step_err: got %b want 0", step_err); end
        n_cmp++; if (dir_up    !== 1'b0) begin n_bad++; $display("FAIL reset_dir_up: got %b want 0", dir_up); end
        n_cmp++; if (locked    !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        reset = 1'b0;
    endtask

    task automatic test_count_up;
        for (int e = 1; e <= 34; e++) begin
            gray_in   = to_gray(5'((e - 1 > 31) ? 31 : e - 1));
            sample_en = (e >= 3);
            tick();
            if (e < 3) begin
                n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL up_early_valid e=%0d: got %b want 0", e, bin_valid); end
                n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL up_early_locked e=%0d: got %b want 0", e, locked); end
            end else begin
                n_cmp++; if (bin_valid !== 1'b1) begin n_bad++; $display("FAIL up_valid e=%0d: got %b want 1", e, bin_valid); end
                n_cmp++; if (bin_out !== 5'(e - 3)) begin n_bad++; $display("FAIL up_bin_out e=%0d: got %0d want %0d", e, bin_out, e - 3); end
                n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL up_locked e=%0d: got %b want 1", e, locked); end
                n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL up_step_err e=%0d: got %b want 0", e, step_err); end
                n_cmp++; if (dir_up !== (e >= 4)) begin n_bad++; $display("FAIL up_dir_up e=%0d: got %b want %b", e, dir_up, e >= 4); end
            end
        end
        sample_en = 1'b0;
        tick();
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL up_valid_drop: got %b want 0", bin_valid); end
    endtask

    task automatic test_wrap;
        present(5'b00000, 1'b0);
        n_cmp++; if (bin_out !== 5'd0) begin n_bad++; $display("FAIL wrap_up_bin: got %0d want 0", bin_out); end
        n_cmp++; if (bin_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_up_valid: got %b want 1", bin_valid); end
        n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL wrap_up_err: got %b want 0", step_err); end
        n_cmp++; if (dir_up !== 1'b1) begin n_bad++; $display("FAIL wrap_up_dir: got %b want 1", dir_up); end
        present(5'b10000, 1'b0);
        n_cmp++; if (bin_out !== 5'd31) begin n_bad++; $display("FAIL wrap_dn_bin: got %0d want 31", bin_out); end
        n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL wrap_dn_err: got %b want 0", step_err); end
        n_cmp++; if (dir_up !== 1'b0) begin n_bad++; $display("FAIL wrap_dn_dir: got %b want 0", dir_up); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL wrap_dn_locked: got %b want 1", locked); end
    endtask

    task automatic test_single_jump;
        present(5'b00000, 1'b0);
        present(5'b00001, 1'b0);
        n_cmp++; if (bin_out !== 5'd1) begin n_bad++; $display("FAIL jump_pre_bin: got %0d want 1", bin_out); end
        n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL jump_pre_err: got %b want 0", step_err); end
        present(5'b00110, 1'b0);
        n_cmp++; if (bin_out !== 5'd4) begin n_bad++; $display("FAIL jump_bin: got %0d want 4", bin_out); end
        n_cmp++; if (step_err !== 1'b1) begin n_bad++; $display("FAIL jump_err: got %b want 1", step_err); end
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL jump_cnt: got %0d want 1", err_count); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL jump_locked: got %b want 1", locked); end
        n_cmp++; if (dir_up !== 1'b1) begin n_bad++; $display("FAIL jump_dir: got %b want 1", dir_up); end
        present(5'b00111, 1'b0);
        n_cmp++; if (bin_out !== 5'd5) begin n_bad++; $display("FAIL recover_bin: got %0d want 5", bin_out); end
        n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL recover_err: got %b want 0", step_err); end
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL recover_cnt: got %0d want 1", err_count); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL recover_locked: got %b want 1", locked); end
    endtask

    task automatic test_lock_loss;
        logic [4:0] jumps [3];
        logic       lk_exp [3];
        jumps  = '{5'd4, 5'd8, 5'd12};
        lk_exp = '{1'b1, 1'b1, 1'b0};
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL clear_only_a: got %0d want 0", err_count); end
        for (int v = 4; v >= 1; v--) begin
            present(to_gray(5'(v)), 1'b0);
            n_cmp++; if (step_err !== 1'b0 || dir_up !== 1'b0 || bin_out !== 5'(v)) begin
                n_bad++; $display("FAIL down_step v=%0d: got err=%b dir=%b bin=%0d want err=0 dir=0 bin=%0d", v, step_err, dir_up, bin_out, v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            present(to_gray(jumps[i]), 1'b0);
            n_cmp++; if (step_err !== 1'b1) begin n_bad++; $display("FAIL loss_err i=%0d: got %b want 1", i, step_err); end
            n_cmp++; if (err_count !== 8'(i + 1)) begin n_bad++; $display("FAIL loss_cnt i=%0d: got %0d want %0d", i, err_count, i + 1); end
            n_cmp++; if (locked !== lk_exp[i]) begin n_bad++; $display("FAIL loss_locked i=%0d: got %b want %b", i, locked, lk_exp[i]); end
        end
        present(to_gray(5'd13), 1'b0);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock_locked: got %b want 1", locked); end
        n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL relock_err: got %b want 0", step_err); end
        n_cmp++; if (bin_out !== 5'd13) begin n_bad++; $display("FAIL relock_bin: got %0d want 13", bin_out); end
        n_cmp++; if (err_count !== 8'd3) begin n_bad++; $display("FAIL relock_cnt: got %0d want 3", err_count); end
    endtask

    task automatic test_clear_and_saturate;
        int unsigned pulses;
        present(to_gray(5'd20), 1'b0);
        present(to_gray(5'd27), 1'b0);
        n_cmp++; if (err_count !== 8'd5) begin n_bad++; $display("FAIL clr_pre_cnt: got %0d want 5", err_count); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL clr_pre_locked: got %b want 1", locked); end
        present(to_gray(5'd2), 1'b1);
        n_cmp++; if (step_err !== 1'b1) begin n_bad++; $display("FAIL clr_bad_err: got %b want 1", step_err); end
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL clr_bad_cnt: got %0d want 1", err_count); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL clr_bad_locked: got %b want 0", locked); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL clr_only_b: got %0d want 0", err_count); end
        // Alternate 0 and 16 every cycle: every locked sample is an illegal step.
        pulses    = 0;
        sample_en = 1'b1;
        for (int c = 0; c < 2000 && pulses < 256; c++) begin
            gray_in = (c % 2 == 0) ? to_gray(5'd16) : to_gray(5'd0);
            tick();
            if (step_err === 1'b1) begin
                pulses++;
                if (pulses == 254) begin
                    n_cmp++; if (err_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", err_count); end
                end
                if (pulses == 255) begin
                    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", err_count); end
                end
                if (pulses == 256) begin
                    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", err_count); end
                end
            end
        end
        sample_en = 1'b0;
        n_cmp++; if (pulses < 256) begin n_bad++; $display("FAIL sat_timeout: got %0d step_err pulses want 256", pulses); end
    endtask

    task automatic test_async_reset;
        present(to_gray(5'd5), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bin_out   !== 5'd0) begin n_bad++; $display("FAIL areset_bin_out: got %0d want 0", bin_out); end
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL areset_bin_valid: got %b want 0", bin_valid); end
        n_cmp++; if (step_err  !== 1'b0) begin n_bad++; $display("FAIL areset_step_err: got %b want 0", step_err); end
        n_cmp++; if (dir_up    !== 1'b0) begin n_bad++; $display("FAIL areset_dir_up: got %b want 0", dir_up); end
        n_cmp++; if (locked    !== 1'b0) begin n_bad++; $display("FAIL areset_locked: got %b want 0", locked); end
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL areset_err_count: got %0d want 0", err_count); end
        tick();
        reset = 1'b0;
        present(to_gray(5'd9), 1'b0);
        n_cmp++; if (bin_out !== 5'd9) begin n_bad++; $display("FAIL post_bin: got %0d want 9", bin_out); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL post_locked: got %b want 1", locked); end
        n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL post_err: got %b want 0", step_err); end
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL post_cnt: got %0d want 0", err_count); end
        n_cmp++; if (dir_up !== 1'b0) begin n_bad++; $display("FAIL post_dir: got %b want 0", dir_up); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_single_jump();
        test_lock_loss();
        test_clear_and_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
